fpu_f32_div_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision divider (O = A / B) with valid/ready handshakes on both sides.
- Responder counterpart to the FPU testbench initiator: accepts one operand pair, iterates a restoring mantissa division, then returns result plus exception flags.
- Replaces the combinational divider where timing closure matters.
- Fixed latency keeps scoreboarding against the golden divide model trivial.

---
 rtl/fpu_f32_pkg.sv | 38 +++
 rtl/fpu_f32_div_round.sv | 74 +++++++
 rtl/fpu_f32_div_seq.sv | 143 ++++++++++++++
 tb/tb_fpu_f32_div_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_f32_pkg.sv
// Shared F32 field layout, flag positions, operand classes and divider FSM states.
package fpu_f32_pkg;

    localparam int          EXP_W             = 8;
    localparam int          MAN_W             = 23;
    localparam int          BIAS              = 127;
    localparam logic [31:0] CANONICAL_NAN_DEF = 32'h7FC00000;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } f32_t;

    typedef enum logic [1:0] {ZERO, NORM, INF, NAN} f32_cls_t;

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} div_state_t;

    // Result override chosen at accept time; SP_NONE means use the iterated quotient.
    typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_DZ, SP_INF, SP_ZERO} div_special_t;

    // Denormals classify as ZERO (flush-to-zero on input).
    function automatic f32_cls_t f32_classify(input f32_t x);
        if (x.exp == '0)
            return ZERO;
        else if (x.exp == '1)
            return (x.man == '0) ? INF : NAN;
        else
            return NORM;
    endfunction

endpackage

// File: rtl/fpu_f32_div_round.sv
// Normalise, round-to-nearest-even and pack a 26-bit quotient, or emit the special-case result.
// Purely combinational; the caller registers O and FLAGS.
module fpu_f32_div_round
    import fpu_f32_pkg::*;
#(
    parameter logic [31:0] CANONICAL_NAN = CANONICAL_NAN_DEF
) (
    input  logic               sign,
    input  logic signed [9:0]  expo,
    input  logic [25:0]        quo,
    input  logic               rem_nz,
    input  div_special_t       special,
    output logic [31:0]        o,
    output logic [4:0]         flags
);

    logic [22:0]       frac;
    logic              guard;
    logic              sticky;
    logic              rnd_up;
    logic [23:0]       frac_r;
    logic signed [9:0] e_n;
    logic signed [9:0] e_r;

    // The hidden bit is known to be set in both alignments, so only the fraction is carried.
    always_comb begin
        if (quo[25]) begin
            frac   = quo[24:2];
            guard  = quo[1];
            sticky = quo[0] | rem_nz;
            e_n    = expo;
        end else begin
            frac   = quo[23:1];
            guard  = quo[0];
            sticky = rem_nz;
            e_n    = expo - 10'sd1;
        end
        rnd_up = guard & (sticky | frac[0]);
        frac_r = {1'b0, frac} + {23'b0, rnd_up};
        e_r    = frac_r[23] ? (e_n + 10'sd1) : e_n;
    end

    always_comb begin
        o     = '0;
        flags = '0;
        case (special)
            SP_NAN: begin
                o              = CANONICAL_NAN;
                flags[FLAG_NV] = 1'b1;
            end
            SP_DZ: begin
                o              = {sign, 8'hFF, 23'b0};
                flags[FLAG_DZ] = 1'b1;
            end
            SP_INF:  o = {sign, 8'hFF, 23'b0};
            SP_ZERO: o = {sign, 31'b0};
            default: begin
                if (e_r >= 10'sd255) begin
                    o              = {sign, 8'hFF, 23'b0};
                    flags[FLAG_OF] = 1'b1;
                    flags[FLAG_NX] = 1'b1;
                end else if (e_r <= 10'sd0) begin
                    o              = {sign, 31'b0};
                    flags[FLAG_UF] = 1'b1;
                    flags[FLAG_NX] = 1'b1;
                end else begin
                    o              = {sign, e_r[7:0], frac_r[22:0]};
                    flags[FLAG_NX] = guard | sticky;
                end
            end
        endcase
    end

endmodule

// File: rtl/fpu_f32_div_seq.sv
// Sequential F32 divider: restoring mantissa division, one quotient bit per cycle.
// Fixed 27-cycle accept-to-valid for every operand; result held in DONE until OUT_READY.
module fpu_f32_div_seq
    import fpu_f32_pkg::*;
#(
    parameter logic [31:0] CANONICAL_NAN = CANONICAL_NAN_DEF,
    parameter int          DIV_BITS      = 26
) (
    input  logic        MCLK,
    input  logic        RST,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] O,
    output logic [4:0]  FLAGS
);

    if (DIV_BITS != 26) begin : g_bad_div_bits
        $error("fpu_f32_div_seq: DIV_BITS must be 26");
    end

    div_state_t        state;
    logic [4:0]        cnt;
    logic [24:0]       rem;
    logic [23:0]       mb;
    logic [25:0]       quo;
    logic              sgn;
    logic signed [9:0] exp_r;
    div_special_t      special;

    f32_t              fa;
    f32_t              fb;
    f32_cls_t          cls_a;
    f32_cls_t          cls_b;
    div_special_t      sp_acc;
    logic signed [9:0] e_acc;

    logic              ge;
    logic [24:0]       rem_sub;
    logic [24:0]       rem_next;

    logic [31:0]       rnd_o;
    logic [4:0]        rnd_flags;

    assign fa    = A;
    assign fb    = B;
    assign cls_a = f32_classify(fa);
    assign cls_b = f32_classify(fb);
    assign e_acc = $signed({2'b0, fa.exp}) - $signed({2'b0, fb.exp}) + 10'(BIAS);

    // Inf/0 is "Inf / finite" (no DZ); only a finite nonzero dividend raises DZ.
    always_comb begin
        if (cls_a == NAN || cls_b == NAN)
            sp_acc = SP_NAN;
        else if ((cls_a == ZERO && cls_b == ZERO) || (cls_a == INF && cls_b == INF))
            sp_acc = SP_NAN;
        else if (cls_a == NORM && cls_b == ZERO)
            sp_acc = SP_DZ;
        else if (cls_a == INF)
            sp_acc = SP_INF;
        else if (cls_b == INF || cls_a == ZERO)
            sp_acc = SP_ZERO;
        else
            sp_acc = SP_NONE;
    end

    // After a subtract the remainder is below mb, so the shift never drops a set bit.
    always_comb begin
        ge       = (rem >= {1'b0, mb});
        rem_sub  = ge ? (rem - {1'b0, mb}) : rem;
        rem_next = rem_sub << 1;
    end

    fpu_f32_div_round #(
        .CANONICAL_NAN (CANONICAL_NAN)
    ) u_round (
        .sign    (sgn),
        .expo    (exp_r),
        .quo     (quo),
        .rem_nz  (|rem),
        .special (special),
        .o       (rnd_o),
        .flags   (rnd_flags)
    );

    always_ff @(posedge MCLK) begin
        if (RST) begin
            state     <= IDLE;
            IN_READY  <= 1'b1;
            OUT_VALID <= 1'b0;
            O         <= '0;
            FLAGS     <= '0;
            cnt       <= '0;
            rem       <= '0;
            mb        <= '0;
            quo       <= '0;
            sgn       <= 1'b0;
            exp_r     <= '0;
            special   <= SP_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID && IN_READY) begin
                        sgn      <= fa.sign ^ fb.sign;
                        exp_r    <= e_acc;
                        rem      <= {2'b01, fa.man};
                        mb       <= {1'b1, fb.man};
                        quo      <= '0;
                        cnt      <= 5'(DIV_BITS - 1);
                        special  <= sp_acc;
                        IN_READY <= 1'b0;
                        state    <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    quo <= {quo[24:0], ge};
                    rem <= rem_next;
                    cnt <= cnt - 5'd1;
                    if (cnt == '0)
                        state <= ROUND;
                end
                ROUND: begin
                    O         <= rnd_o;
                    FLAGS     <= rnd_flags;
                    OUT_VALID <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_f32_div_seq.sv
// Scoreboard bench for fpu_f32_div_seq: expected results queued at accept, compared at the output handshake.
module tb_fpu_f32_div_seq;

    logic        MCLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [31:0] O;
    logic [4:0]  FLAGS;

    fpu_f32_div_seq dut (
        .MCLK      (MCLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .O         (O),
        .FLAGS     (FLAGS)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        logic [31:0] o;
        logic [4:0]  f;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_hs = -1;
    int          last_acc = -1;
    int          ir_seen = 0;
    logic        ov_prev = 1'b0;
    logic        hold_vld = 1'b0;
    logic [31:0] hold_o = '0;
    logic [4:0]  hold_f = '0;
    logic [31:0] pend_o = '0;
    logic [4:0]  pend_f = '0;

    localparam int LAT = 28;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    always @(posedge MCLK) cyc <= cyc + 1;

    // Latency is counted as the number of edges from the accepting edge to the first edge that samples OUT_VALID high.
    always @(negedge MCLK) begin
        exp_t ent;
        if (RST) begin
            sb.delete();
            ov_prev  = 1'b0;
            hold_vld = 1'b0;
        end else begin
            if (sb.size() > 0 && IN_READY)
                ir_seen = 1;
            if (OUT_VALID && hold_vld) begin
                chk("o_hold", O, hold_o);
                chk("flags_hold", {27'b0, FLAGS}, {27'b0, hold_f});
            end
            if (OUT_VALID && !ov_prev) begin
                if (sb.size() == 0)
                    chk("spurious_out_valid", {31'b0, OUT_VALID}, 32'd0);
                else begin
                    chk("latency", cyc + 1 - sb[0].acc, LAT);
                    chk("in_ready_at_valid", {31'b0, IN_READY}, 32'd0);
                end
            end
            if (OUT_VALID && OUT_READY && sb.size() > 0) begin
                ent = sb.pop_front();
                chk("o", O, ent.o);
                chk("flags", {27'b0, FLAGS}, {27'b0, ent.f});
                chk("in_ready_low_busy", ir_seen, 0);
                last_hs = cyc + 1;
            end
            if (IN_VALID && IN_READY) begin
                sb.push_back('{pend_o, pend_f, cyc + 1});
                last_acc = cyc + 1;
                ir_seen  = 0;
            end
            hold_vld = OUT_VALID && !OUT_READY;
            hold_o   = O;
            hold_f   = FLAGS;
            ov_prev  = OUT_VALID;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eo, input logic [4:0] ef);
        int   n;
        logic rdy;
        @(posedge MCLK);
        #1;
        A        = a;
        B        = b;
        pend_o   = eo;
        pend_f   = ef;
        IN_VALID = 1'b1;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 200) begin
            @(negedge MCLK);
            rdy = IN_READY;
            @(posedge MCLK);
            n++;
        end
        #1;
        IN_VALID = 1'b0;
        if (!rdy)
            chk("accept_timeout", {31'b0, rdy}, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge MCLK);
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] o;
        logic [4:0]  f;
    } vec_t;

    vec_t vecs[$] = '{
        '{32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000},  // 6/2
        '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001},  // 1/3
        '{32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 5'b00001},  // -1/3
        '{32'h40000000, 32'h40400000, 32'h3F2AAAAB, 5'b00001},  // 2/3
        '{32'h3FC00000, 32'h3F800000, 32'h3FC00000, 5'b00000},  // 1.5/1
        '{32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000},  // 1/0
        '{32'h00000000, 32'h80000000, 32'h7FC00000, 5'b10000},  // 0/-0
        '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000},  // NaN/1
        '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000},  // Inf/Inf
        '{32'h7F800000, 32'h40000000, 32'h7F800000, 5'b00000},  // Inf/2
        '{32'hC0000000, 32'h7F800000, 32'h80000000, 5'b00000},  // -2/Inf
        '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 5'b00101},  // overflow
        '{32'h00800000, 32'h40000000, 32'h00000000, 5'b00011},  // underflow
        '{32'h00400000, 32'h3F800000, 32'h00000000, 5'b00000}   // denormal dividend
    };

    initial begin
        RST = 1'b1;
        repeat (3) @(posedge MCLK);
        #1 RST = 1'b0;
        @(negedge MCLK);
        chk("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("rst_in_ready", {31'b0, IN_READY}, 32'd1);
        chk("rst_o", O, 32'd0);
        chk("rst_flags", {27'b0, FLAGS}, 32'd0);

        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].f);
            drain();
        end

        // Backpressure: hold the 6/2 result for 10 cycles while 1/3 waits at the input.
        @(posedge MCLK);
        #1 OUT_READY = 1'b0;
        send(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000);
        fork
            send(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001);
            begin
                int n;
                n = 0;
                while (!OUT_VALID && n < 60) begin
                    @(negedge MCLK);
                    n++;
                end
                repeat (10) begin
                    @(negedge MCLK);
                    chk("bp_out_valid", {31'b0, OUT_VALID}, 32'd1);
                    chk("bp_in_ready", {31'b0, IN_READY}, 32'd0);
                end
                @(posedge MCLK);
                #1 OUT_READY = 1'b1;
            end
        join
        chk("accept_after_hs", last_acc, last_hs + 1);
        drain();

        // Reset while DIVIDE counter is at 15 discards the operation.
        send(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000);
        repeat (10) @(posedge MCLK);
        #1 RST = 1'b1;
        @(posedge MCLK);
        #1 RST = 1'b0;
        @(negedge MCLK);
        chk("midrst_out_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("midrst_in_ready", {31'b0, IN_READY}, 32'd1);
        chk("midrst_o", O, 32'd0);
        chk("midrst_flags", {27'b0, FLAGS}, 32'd0);
        repeat (35) @(negedge MCLK);
        send(32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000);
        drain();

        repeat (3) @(posedge MCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
